tff_down_counter: RTL

//  Synchronous loadable down counter built from a chain of T flip-flops; the count-down

---
 rtl/tff_down_counter.sv | 105 ++++++++++
 1 files changed

// File: rtl/tff_down_counter.sv
// Loadable down counter built from a chain of T flip-flops. It flags zero and,
// depending on WRAP, either wraps with a borrow pulse or stops at zero and sets done.
module tff_down_counter #(
  parameter int WIDTH = 4,
  parameter bit WRAP  = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             T0,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] Y,
  output logic             Q0,
  output logic             Q1,
  output logic             Q2,
  output logic             Q3,
  output logic             zero,
  output logic             borrow,
  output logic             done
);

  typedef enum logic [1:0] {IDLE, RUN, HALT} state_t;

  state_t           state, state_next;
  logic             count_en;
  logic             hit_end;
  logic             wrap_now;
  logic [WIDTH-1:0] toggle;
  logic             lower_zero;
  logic [3:0]       q_ext;

  assign zero  = (Y == '0);
  assign q_ext = 4'(Y);
  assign Q0    = q_ext[0];
  assign Q1    = q_ext[1];
  assign Q2    = q_ext[2];
  assign Q3    = q_ext[3];

  always_comb begin
    state_next = state;
    count_en   = 1'b0;
    hit_end    = 1'b0;
    wrap_now   = 1'b0;
    case (state)
      IDLE: if (load) state_next = RUN;
      RUN: begin
        if (load) begin
          state_next = RUN;
        end else if (T0) begin
          if (WRAP) begin
            count_en = 1'b1;
            wrap_now = zero;
          end else if (zero) begin
            // A one-shot loaded with zero finishes without wrapping.
            hit_end    = 1'b1;
            state_next = HALT;
          end else begin
            count_en = 1'b1;
            if (Y == WIDTH'(1)) begin
              hit_end    = 1'b1;
              state_next = HALT;
            end
          end
        end
      end
      HALT: if (load) state_next = RUN;
      default: state_next = IDLE;
    endcase
  end

  // A bit toggles on a decrement only when every lower bit is already zero.
  always_comb begin
    toggle     = '0;
    lower_zero = 1'b1;
    for (int i = 0; i < WIDTH; i++) begin
      toggle[i]  = count_en & lower_zero;
      lower_zero = lower_zero & ~Y[i];
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      Y      <= '0;
      borrow <= 1'b0;
      done   <= 1'b0;
    end else if (load) begin
      Y      <= load_val;
      borrow <= 1'b0;
      done   <= 1'b0;
    end else begin
      Y      <= Y ^ toggle;
      borrow <= wrap_now;
      if (hit_end) done <= 1'b1;
    end
  end

endmodule
